// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl -- MEM-stage MMIO controller for the 5-stage RISC-V core.
//   Decodes addr[31:28] into BRAM / LED / KBD / VGA / NUM / TIMER regions,
//   returns combinational read data, applies byte-enabled register writes,
//   buffers PS2 scancodes in a FIFO (popped by lw 0x30000000), and provides
//   a sticky W1C overflow flag, a maskable level IRQ and a free-running timer.
// Ports:
//   clk, rst (async, active-low)
//   mem_read, mem_write, addr, write_data, byte_en : MEM-stage access
//   bram_data                                      : BRAM read data
//   ps2_code, ps2_strobe                           : scancode input
//   num_buffer, num_valid                          : number input buffer
//   data_out                                       : read data to writeback
//   led_reg, vga_result                            : output registers
//   is_bram_write                                  : BRAM write enable
//   irq                                            : irq_en & FIFO non-empty
module mmio_bus_ctrl #(
   parameter int unsigned LED_W      = 16,
   parameter int unsigned VGA_W      = 2,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [31:0]       write_data,
   input  logic [3:0]        byte_en,
   input  logic [31:0]       bram_data,
   input  logic [7:0]        ps2_code,
   input  logic              ps2_strobe,
   input  logic [31:0]       num_buffer,
   input  logic              num_valid,
   output logic [31:0]       data_out,
   output logic [LED_W-1:0]  led_reg,
   output logic [VGA_W-1:0]  vga_result,
   output logic              is_bram_write,
   output logic              irq
);

   localparam int unsigned     PTR_W    = CNT_W - 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   localparam logic [3:0] RG_BRAM  = 4'h0;
   localparam logic [3:0] RG_LED   = 4'h2;
   localparam logic [3:0] RG_KBD   = 4'h3;
   localparam logic [3:0] RG_VGA   = 4'h4;
   localparam logic [3:0] RG_NUM   = 4'h5;
   localparam logic [3:0] RG_TIMER = 4'h6;

   logic [LED_W-1:0] led_q, led_d;
   logic [VGA_W-1:0] vga_q, vga_d;
   logic [31:0]      timer_q, timer_d;
   logic [7:0]       fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             irq_en_q, irq_en_d;

   logic [3:0]  region;
   logic [1:0]  off;
   logic        led_we, vga_we, tmr_we, ctrl_we;
   logic        empty, full, pop, push, drop;
   logic [31:0] led_ext, vga_ext, status;

   assign region = addr[31:28];
   assign off    = addr[3:2];

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign pop   = mem_read & (addr == 32'h3000_0000) & ~empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
   assign push  = ps2_strobe & (~full | pop);
   assign drop  = ps2_strobe & full & ~pop;

   assign led_we  = mem_write & (region == RG_LED)   & (off == 2'd0);
   assign vga_we  = mem_write & (region == RG_VGA)   & (off == 2'd0);
   assign tmr_we  = mem_write & (region == RG_TIMER) & (off == 2'd0);
   assign ctrl_we = mem_write & (region == RG_KBD)   & (off == 2'd2);

   assign is_bram_write = mem_write & (region == RG_BRAM);
   assign irq           = irq_en_q & ~empty;
   assign led_reg       = led_q;
   assign vga_result    = vga_q;

   always_comb begin
      led_ext = '0;
      led_ext[LED_W-1:0] = led_q;
      vga_ext = '0;
      vga_ext[VGA_W-1:0] = vga_q;
      status = '0;
      status[CNT_W+1:2] = count_q;
      status[1] = full;
      status[0] = ~empty;
   end

   // Byte-enabled merges are done bit by bit so bits beyond each
   // register's width never enter the datapath.
   always_comb begin
      led_d   = led_q;
      vga_d   = vga_q;
      timer_d = timer_q + 32'd1;
      if (led_we) begin
         for (int unsigned b = 0; b < LED_W; b++)
            if (byte_en[b/8]) led_d[b] = write_data[b];
      end
      if (vga_we) begin
         for (int unsigned b = 0; b < VGA_W; b++)
            if (byte_en[b/8]) vga_d[b] = write_data[b];
      end
      if (tmr_we) begin
         timer_d = timer_q;
         for (int unsigned b = 0; b < 32; b++)
            if (byte_en[b/8]) timer_d[b] = write_data[b];
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q + (pop  ? PTR_W'(1) : '0);
      wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : '0);
      count_d  = count_q;
      if (push & ~pop)      count_d = count_q + CNT_W'(1);
      else if (pop & ~push) count_d = count_q - CNT_W'(1);
      irq_en_d = irq_en_q;
      if (ctrl_we & byte_en[0]) irq_en_d = write_data[1];
      // Overflow set takes priority over a same-cycle W1C.
      ovf_d = ovf_q;
      if (drop)                                     ovf_d = 1'b1;
      else if (ctrl_we & byte_en[0] & write_data[0]) ovf_d = 1'b0;
   end

   always_comb begin
      data_out = '0;
      case (region)
         RG_BRAM:  data_out = bram_data;
         RG_LED:   if (off == 2'd0) data_out = led_ext;
         RG_KBD: begin
            case (off)
               2'd0:    data_out = empty ? '0 : {24'b0, fifo_q[rd_ptr_q]};
               2'd1:    data_out = status;
               2'd2:    data_out = {30'b0, irq_en_q, ovf_q};
               default: data_out = '0;
            endcase
         end
         RG_VGA:   if (off == 2'd0) data_out = vga_ext;
         RG_NUM: begin
            if (off == 2'd0)      data_out = num_buffer;
            else if (off == 2'd1) data_out = {31'b0, num_valid};
         end
         RG_TIMER: if (off == 2'd0) data_out = timer_q;
         default:  data_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q    <= '0;
         vga_q    <= '0;
         timer_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
      end else begin
         led_q    <= led_d;
         vga_q    <= vga_d;
         timer_q  <= timer_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else if (push) begin
         fifo_q[wr_ptr_q] <= ps2_code;
      end
   end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb_mmio_bus_ctrl -- directed bench for mmio_bus_ctrl. Stimulus pushes
// hand-computed expectations into a scoreboard queue; a monitor samples the
// DUT on the falling edge and compares.
module tb_mmio_bus_ctrl;

   localparam int unsigned LED_W      = 16;
   localparam int unsigned VGA_W      = 2;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned CNT_W      = 4;

   localparam int unsigned S_DATA = 0;
   localparam int unsigned S_LED  = 1;
   localparam int unsigned S_VGA  = 2;
   localparam int unsigned S_BWR  = 3;
   localparam int unsigned S_IRQ  = 4;

   localparam logic [31:0] A_LED  = 32'h2000_0000;
   localparam logic [31:0] A_HEAD = 32'h3000_0000;
   localparam logic [31:0] A_STAT = 32'h3000_0004;
   localparam logic [31:0] A_CTRL = 32'h3000_0008;
   localparam logic [31:0] A_VGA  = 32'h4000_0000;
   localparam logic [31:0] A_NUM  = 32'h5000_0000;
   localparam logic [31:0] A_NUMV = 32'h5000_0004;
   localparam logic [31:0] A_TMR  = 32'h6000_0000;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0]      addr = '0, write_data = '0;
   logic [3:0]       byte_en = '0;
   logic [31:0]      bram_data = 32'hDEAD_BEEF;
   logic [7:0]       ps2_code = '0;
   logic             ps2_strobe = 1'b0;
   logic [31:0]      num_buffer = 32'h1234_5678;
   logic             num_valid = 1'b1;
   logic [31:0]      data_out;
   logic [LED_W-1:0] led_reg;
   logic [VGA_W-1:0] vga_result;
   logic             is_bram_write;
   logic             irq;

   mmio_bus_ctrl #(
      .LED_W(LED_W), .VGA_W(VGA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .write_data(write_data), .byte_en(byte_en),
      .bram_data(bram_data), .ps2_code(ps2_code), .ps2_strobe(ps2_strobe),
      .num_buffer(num_buffer), .num_valid(num_valid), .data_out(data_out),
      .led_reg(led_reg), .vga_result(vga_result),
      .is_bram_write(is_bram_write), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int unsigned sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int unsigned checks = 0;
   int unsigned errors = 0;

   function automatic logic [31:0] observe(input int unsigned sel);
      case (sel)
         S_DATA:  return data_out;
         S_LED:   return 32'(led_reg);
         S_VGA:   return 32'(vga_result);
         S_BWR:   return {31'b0, is_bram_write};
         default: return {31'b0, irq};
      endcase
   endfunction

   // Monitor: every falling edge, consume all pending expectations.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() != 0) begin
            exp_t e;
            logic [31:0] got;
            e = sb.pop_front();
            got = observe(e.sel);
            checks++;
            if (got !== e.exp) begin
               errors++;
               $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.exp);
            end
         end
      end
   end

   task automatic expect_v(input string n, input int unsigned sel, input logic [31:0] v);
      sb.push_back('{name: n, sel: sel, exp: v});
   endtask

   task automatic cyc(input logic rd_i, input logic wr_i, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic stb, input logic [7:0] code);
      @(posedge clk);
      #1;
      mem_read   = rd_i;
      mem_write  = wr_i;
      addr       = a;
      write_data = wd;
      byte_en    = be;
      ps2_strobe = stb;
      ps2_code   = code;
   endtask

   task automatic rd(input logic [31:0] a, input string n, input logic [31:0] v);
      cyc(1'b1, 1'b0, a, '0, '0, 1'b0, '0);
      expect_v(n, S_DATA, v);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      cyc(1'b0, 1'b1, a, d, be, 1'b0, '0);
   endtask

   task automatic push_code(input logic [7:0] c);
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b1, c);
   endtask

   task automatic nop();
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      finish_run();
   end

   initial begin
      // T1: reset state and timer start
      nop();
      expect_v("rst_data_bram", S_DATA, 32'hDEAD_BEEF);
      expect_v("rst_led", S_LED, 32'h0);
      expect_v("rst_vga", S_VGA, 32'h0);
      expect_v("rst_irq", S_IRQ, 32'h0);
      expect_v("rst_bwr", S_BWR, 32'h0);
      rd(A_TMR, "rst_timer", 32'h0);
      rst = 1'b1;
      rd(A_TMR, "timer_1", 32'd1);
      rd(A_TMR, "timer_2", 32'd2);
      rd(A_TMR, "timer_3", 32'd3);

      // Timer load, wrap, and byte merge
      wr(A_TMR, 32'hFFFF_FFFF, 4'hF);
      rd(A_TMR, "timer_load_max", 32'hFFFF_FFFF);
      rd(A_TMR, "timer_wrap", 32'h0);
      wr(A_TMR, 32'h0000_3400, 4'b0010);
      rd(A_TMR, "timer_merge", 32'h0000_3401);

      // T2: LED byte enables
      wr(A_LED, 32'hA5A5_1234, 4'b0001);
      rd(A_LED, "led_be0_rd", 32'h0000_0034);
      expect_v("led_be0_port", S_LED, 32'h0000_0034);
      wr(A_LED, 32'hA5A5_1234, 4'b0010);
      rd(A_LED, "led_be1_rd", 32'h0000_1234);
      wr(A_LED, 32'hA5A5_FFFF, 4'b1100);
      rd(A_LED, "led_hi_lanes", 32'h0000_1234);
      expect_v("led_hi_port", S_LED, 32'h0000_1234);

      // VGA and NUM
      wr(A_VGA, 32'hFFFF_FFFF, 4'b0001);
      rd(A_VGA, "vga_trunc", 32'h3);
      expect_v("vga_port", S_VGA, 32'h3);
      rd(A_NUM, "num_buf", 32'h1234_5678);
      rd(A_NUMV, "num_valid", 32'h1);

      // T3: FIFO push/pop
      push_code(8'h1C);
      push_code(8'h32);
      rd(A_STAT, "fifo_stat2", 32'h9);
      expect_v("irq_masked", S_IRQ, 32'h0);
      rd(A_HEAD, "fifo_pop1", 32'h1C);
      rd(A_HEAD, "fifo_pop2", 32'h32);
      rd(A_STAT, "fifo_stat0", 32'h0);
      rd(A_HEAD, "fifo_empty_pop", 32'h0);
      rd(A_STAT, "fifo_no_underflow", 32'h0);

      // T4: overflow
      for (int unsigned i = 0; i < 9; i++) push_code(8'(8'h10 + i));
      rd(A_STAT, "ovf_stat_full", 32'h23);
      rd(A_CTRL, "ovf_set", 32'h1);
      wr(A_CTRL, 32'h1, 4'h1);
      rd(A_CTRL, "ovf_w1c", 32'h0);

      // T5: simultaneous push and pop on a full FIFO
      cyc(1'b1, 1'b0, A_HEAD, '0, '0, 1'b1, 8'h99);
      expect_v("simul_head", S_DATA, 32'h10);
      rd(A_STAT, "simul_stat", 32'h23);
      rd(A_CTRL, "simul_no_ovf", 32'h0);

      // Overflow set beats same-cycle W1C
      cyc(1'b0, 1'b1, A_CTRL, 32'h1, 4'h1, 1'b1, 8'hEE);
      rd(A_CTRL, "set_wins", 32'h1);
      wr(A_CTRL, 32'h1, 4'h1);
      rd(A_CTRL, "ovf_clear2", 32'h0);

      for (int unsigned i = 0; i < 7; i++) rd(A_HEAD, "drain", 32'(8'h11 + i));
      rd(A_HEAD, "drain_last_new", 32'h99);
      rd(A_STAT, "drain_empty", 32'h0);

      // T6: irq and decoding
      wr(A_CTRL, 32'h2, 4'h1);
      rd(A_CTRL, "irq_en_rd", 32'h2);
      expect_v("irq_empty", S_IRQ, 32'h0);
      push_code(8'h55);
      nop();
      expect_v("irq_set", S_IRQ, 32'h1);
      rd(A_HEAD, "irq_pop", 32'h55);
      expect_v("irq_during_pop", S_IRQ, 32'h1);
      nop();
      expect_v("irq_clear", S_IRQ, 32'h0);
      wr(32'h7000_0000, 32'hFFFF_FFFF, 4'hF);
      expect_v("bwr_other", S_BWR, 32'h0);
      rd(32'h7000_0000, "other_read0", 32'h0);
      expect_v("other_no_led", S_LED, 32'h1234);
      wr(32'h0000_0010, 32'h1, 4'hF);
      expect_v("bwr_bram", S_BWR, 32'h1);
      expect_v("bram_read", S_DATA, 32'hDEAD_BEEF);
      rd(32'h0000_0010, "bram_rd_only", 32'hDEAD_BEEF);
      expect_v("bwr_read", S_BWR, 32'h0);

      // Reset mid-operation
      push_code(8'h77);
      wr(A_LED, 32'h0000_BEEF, 4'b0011);
      rd(A_STAT, "pre_rst_stat", 32'h5);
      expect_v("pre_rst_irq", S_IRQ, 32'h1);
      expect_v("pre_rst_led", S_LED, 32'hBEEF);
      rd(A_STAT, "midrst_stat", 32'h0);
      rst = 1'b0;
      expect_v("midrst_led", S_LED, 32'h0);
      expect_v("midrst_irq", S_IRQ, 32'h0);
      rd(A_CTRL, "midrst_ctrl", 32'h0);
      rst = 1'b1;
      rd(A_HEAD, "post_rst_head", 32'h0);

      nop();
      nop();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      finish_run();
   end

endmodule
